// File: rtl/pixel_pkg.sv
// Shared types and constants for the RGB stream packer: phase encoding and
// the 4-pixel -> 3-word little-endian packing function.
package pixel_pkg;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } pack_phase_t;

  localparam int PIX_W        = 24;
  localparam int WORD_W       = 32;
  localparam int PIX_PER_GRP  = 4;
  localparam int WORD_PER_GRP = 3;

  // Word completed by pixel p in the given phase; hold carries the leftover bytes.
  function automatic logic [WORD_W-1:0] pack_word(input pack_phase_t ph,
                                                   input logic [PIX_W-1:0] p,
                                                   input logic [PIX_W-1:0] hold);
    logic [WORD_W-1:0] w;
    w = 32'h0000_0000;
    case (ph)
      PH1:     w = {p[7:0],  hold[23:0]};
      PH2:     w = {p[15:0], hold[15:0]};
      PH3:     w = {p[23:0], hold[7:0]};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rgb_stream_packer_raster.sv
// Raster position tracker: x/y advance on each accepted pixel and wrap at
// the line and frame boundaries; eol/eof describe the current position.
module raster_counter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      step,
  output logic [((H_RES > 1) ? $clog2(H_RES) : 1)-1:0] x,
  output logic [((V_RES > 1) ? $clog2(V_RES) : 1)-1:0] y,
  output logic                                      eol,
  output logic                                      eof
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;

  assign x   = x_r;
  assign y   = y_r;
  assign eol = (x_r == X_LAST);
  assign eof = (x_r == X_LAST) && (y_r == Y_LAST);

  // Position counters, frozen whenever no pixel is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r <= {XW{1'b0}};
      y_r <= {YW{1'b0}};
    end else if (step) begin
      if (eol) begin
        x_r <= {XW{1'b0}};
        y_r <= eof ? {YW{1'b0}} : (y_r + YW'(1));
      end else begin
        x_r <= x_r + XW'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI4-Stream video words (4 px -> 3 words)
// with tuser on the first word of a frame and tlast on the last word of a line.
module rgb_stream_packer
  import pixel_pkg::*;
#(
  parameter int PIX_WIDTH = 24,
  parameter int OUT_WIDTH = 32,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_WIDTH-1:0] pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [OUT_WIDTH-1:0] out_tdata,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic                 out_tuser,
  output logic                 out_tlast,
  output logic                 frame_done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  if (H_RES % PIX_PER_GRP != 0) begin : g_bad_hres
    $error("rgb_stream_packer: H_RES must be a multiple of 4");
  end
  if (PIX_WIDTH != PIX_W || OUT_WIDTH != WORD_W) begin : g_bad_width
    $error("rgb_stream_packer: only 24-bit pixels and 32-bit words are supported");
  end

  pack_phase_t       phase_r, phase_nxt_s;
  logic [PIX_W-1:0]  hold_r, hold_nxt_s;
  logic [WORD_W-1:0] word_s;
  logic              pix_acc_s, word_acc_s, load_s;
  logic              sof_pend_r, eof_word_r;
  logic [XW-1:0]     x_s;
  logic [YW-1:0]     y_s;
  logic              eol_s, eof_s;

  logic [WORD_W-1:0] tdata_r;
  logic              tvalid_r, tuser_r, tlast_r, frame_done_r;

  // Accepting a pixel in PH0 never produces a word, so it can always proceed.
  assign pix_ready  = (phase_r == PH0) | ~tvalid_r | out_tready;
  assign pix_acc_s  = pix_valid & pix_ready;
  assign word_acc_s = tvalid_r & out_tready;
  assign word_s     = pack_word(phase_r, pix_in, hold_r);

  assign out_tdata  = tdata_r;
  assign out_tvalid = tvalid_r;
  assign out_tuser  = tuser_r;
  assign out_tlast  = tlast_r;
  assign frame_done = frame_done_r;

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster (
    .clk  (clk),
    .rst  (rst),
    .step (pix_acc_s),
    .x    (x_s),
    .y    (y_s),
    .eol  (eol_s),
    .eof  (eof_s)
  );

  // Phase state register and hold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= PH0;
      hold_r  <= 24'h00_0000;
    end else begin
      phase_r <= phase_nxt_s;
      hold_r  <= hold_nxt_s;
    end
  end

  // Next phase, leftover bytes to hold, and whether a word completes now
  always_comb begin
    phase_nxt_s = phase_r;
    hold_nxt_s  = hold_r;
    load_s      = 1'b0;
    if (pix_acc_s) begin
      case (phase_r)
        PH0: begin
          hold_nxt_s  = pix_in;
          phase_nxt_s = PH1;
        end
        PH1: begin
          hold_nxt_s  = {8'h00, pix_in[23:8]};
          load_s      = 1'b1;
          phase_nxt_s = PH2;
        end
        PH2: begin
          hold_nxt_s  = {16'h0000, pix_in[23:16]};
          load_s      = 1'b1;
          phase_nxt_s = PH3;
        end
        PH3: begin
          load_s      = 1'b1;
          phase_nxt_s = PH0;
        end
        default: begin
          phase_nxt_s = PH0;
        end
      endcase
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // Start-of-frame flag: armed by pixel (0,0), consumed by the next word out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_pend_r <= 1'b1;
    end else if (pix_acc_s && (x_s == {XW{1'b0}}) && (y_s == {YW{1'b0}})) begin
      sof_pend_r <= 1'b1;
    end else if (load_s) begin
      sof_pend_r <= 1'b0;
    end
  end

  // AXIS output register; loads only when empty or draining this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_r      <= 32'h0000_0000;
      tvalid_r     <= 1'b0;
      tuser_r      <= 1'b0;
      tlast_r      <= 1'b0;
      eof_word_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= word_acc_s & tlast_r & eof_word_r;
      if (load_s) begin
        tdata_r    <= word_s;
        tvalid_r   <= 1'b1;
        tuser_r    <= sof_pend_r;
        tlast_r    <= (phase_r == PH3) & eol_s;
        eof_word_r <= (phase_r == PH3) & eof_s;
      end else if (word_acc_s) begin
        tvalid_r   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Randomized self-checking bench: a byte-queue reference model predicts every
// word, tuser, tlast and frame_done pulse from the accepted pixel stream.
module tb_rgb_stream_packer;

  localparam int H     = 8;
  localparam int V     = 2;
  localparam int FRAME = H * V;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_in = 24'h0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b0;
  logic        out_tuser;
  logic        out_tlast;
  logic        frame_done;

  rgb_stream_packer #(
    .PIX_WIDTH (24),
    .OUT_WIDTH (32),
    .H_RES     (H),
    .V_RES     (V)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tuser  (out_tuser),
    .out_tlast  (out_tlast),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic        u;
    logic        l;
    logic        f;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  byte_q[$];
  logic [31:0] obs_q[$];
  int          pix_idx = 0;
  int          fd_count = 0;
  logic        fd_exp = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] held_d;
  logic        held_u, held_l;
  int          rdy_mode = 0;

  // Reference model and output monitor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    int   fpos;
    if (rst) begin
      exp_q.delete();
      byte_q.delete();
      pix_idx    = 0;
      fd_exp     = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check_eq("frame_done", {31'b0, frame_done}, {31'b0, fd_exp});
      if (frame_done) fd_count++;
      fd_exp = 1'b0;
      if (stall_prev && out_tvalid) begin
        check_eq("stable_tdata", out_tdata, held_d);
        check_eq("stable_tuser", {31'b0, out_tuser}, {31'b0, held_u});
        check_eq("stable_tlast", {31'b0, out_tlast}, {31'b0, held_l});
      end
      if (out_tvalid && out_tready) begin
        obs_q.push_back(out_tdata);
        if (exp_q.size() == 0) begin
          check_eq("spurious_word", out_tdata, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check_eq("tdata", out_tdata, e.d);
          check_eq("tuser", {31'b0, out_tuser}, {31'b0, e.u});
          check_eq("tlast", {31'b0, out_tlast}, {31'b0, e.l});
          fd_exp = e.f;
        end
      end
      stall_prev = out_tvalid && !out_tready;
      held_d = out_tdata;
      held_u = out_tuser;
      held_l = out_tlast;
      if (pix_valid && pix_ready) begin
        byte_q.push_back(pix_in[7:0]);
        byte_q.push_back(pix_in[15:8]);
        byte_q.push_back(pix_in[23:16]);
        fpos = pix_idx % FRAME;
        if (fpos % 4 != 0) begin
          e.d[7:0]   = byte_q.pop_front();
          e.d[15:8]  = byte_q.pop_front();
          e.d[23:16] = byte_q.pop_front();
          e.d[31:24] = byte_q.pop_front();
          e.u = (fpos == 1);
          e.l = ((fpos % H) == H - 1);
          e.f = (fpos == FRAME - 1);
          exp_q.push_back(e);
        end
        pix_idx++;
      end
    end
  end

  // Downstream ready generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_tready = 1'b1;
        1:       out_tready = 1'($urandom_range(0, 1));
        default: out_tready = 1'b0;
      endcase
    end
  end

  task automatic push(input logic [23:0] p);
    bit done;
    done      = 1'b0;
    pix_in    = p;
    pix_valid = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check_eq("push_timeout", 32'd0, 32'd1);
    pix_valid = 1'b0;
    pix_in    = 24'($urandom);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_tvalid) done = 1'b1;
    end
    check_eq("drain_left", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_tvalid"}, {31'b0, out_tvalid}, 32'd0);
    check_eq({tag, "_tdata"}, out_tdata, 32'd0);
    check_eq({tag, "_tuser"}, {31'b0, out_tuser}, 32'd0);
    check_eq({tag, "_tlast"}, {31'b0, out_tlast}, 32'd0);
    check_eq({tag, "_fdone"}, {31'b0, frame_done}, 32'd0);
    check_eq({tag, "_pready"}, {31'b0, pix_ready}, 32'd1);
  endtask

  int base;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed first group
    push(24'h112233);
    push(24'h445566);
    push(24'h778899);
    push(24'hAABBCC);
    drain();
    check_eq("t1_count", obs_q.size(), 32'd3);
    if (obs_q.size() >= 3) begin
      check_eq("t1_w0", obs_q[0], 32'h66112233);
      check_eq("t1_w1", obs_q[1], 32'h88994455);
      check_eq("t1_w2", obs_q[2], 32'hAABBCC77);
    end

    // Backpressure: downstream stalls with a word pending
    rdy_mode = 2;
    @(posedge clk);
    #2;
    fork
      begin
        for (int i = 0; i < 4; i++) push(24'($urandom));
      end
      begin
        repeat (8) @(negedge clk);
        check_eq("t2_pready_low", {31'b0, pix_ready}, 32'd0);
        check_eq("t2_tvalid_high", {31'b0, out_tvalid}, 32'd1);
        rdy_mode = 0;
      end
    join
    drain();
    check_eq("t2_count", obs_q.size(), 32'd6);

    // Finish the frame: line end at word 12 and one frame_done pulse
    for (int i = 0; i < 8; i++) push(24'($urandom));
    drain();
    check_eq("t3_count", obs_q.size(), 32'd12);
    check_eq("t3_fdone_count", fd_count, 32'd1);

    // Three random frames with gaps and random ready
    rdy_mode = 1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #1;
      push(24'($urandom));
    end
    rdy_mode = 0;
    drain();
    check_eq("t4_fdone_count", fd_count, 32'd4);

    // Reset mid-frame, then restart at pixel (0,0)
    for (int i = 0; i < 5; i++) push(24'($urandom));
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = obs_q.size();
    for (int i = 0; i < 4; i++) push(24'($urandom));
    drain();
    check_eq("t5_count", obs_q.size() - base, 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
